// File: rtl/alu_pkg.sv
// ALU issue stage shared definitions.
// ALU opcodes, entry bundle and opcode classification helpers.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int ALUC_W = 6;

  localparam logic [ALUC_W-1:0] ALUC_ADD  = 6'b100000;
  localparam logic [ALUC_W-1:0] ALUC_ADDU = 6'b100001;
  localparam logic [ALUC_W-1:0] ALUC_SUB  = 6'b100010;
  localparam logic [ALUC_W-1:0] ALUC_SUBU = 6'b100011;
  localparam logic [ALUC_W-1:0] ALUC_AND  = 6'b100100;
  localparam logic [ALUC_W-1:0] ALUC_OR   = 6'b100101;
  localparam logic [ALUC_W-1:0] ALUC_XOR  = 6'b100110;
  localparam logic [ALUC_W-1:0] ALUC_NOR  = 6'b100111;
  localparam logic [ALUC_W-1:0] ALUC_SLT  = 6'b101010;
  localparam logic [ALUC_W-1:0] ALUC_SLTU = 6'b101011;
  localparam logic [ALUC_W-1:0] ALUC_SLL  = 6'b000000;
  localparam logic [ALUC_W-1:0] ALUC_SRL  = 6'b000010;
  localparam logic [ALUC_W-1:0] ALUC_SRA  = 6'b000011;
  localparam logic [ALUC_W-1:0] ALUC_SLLV = 6'b000100;
  localparam logic [ALUC_W-1:0] ALUC_SRLV = 6'b000110;
  localparam logic [ALUC_W-1:0] ALUC_SRAV = 6'b000111;
  localparam logic [ALUC_W-1:0] ALUC_LUI  = 6'b001111;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ALUC_W-1:0] aluc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              a_is_reg;
    logic              b_is_reg;
  } entry_t;

  function automatic logic is_shamt_op(
    input logic [ALUC_W-1:0] aluc
  );
    return (aluc == ALUC_SLL) ||
           (aluc == ALUC_SRL) ||
           (aluc == ALUC_SRA);
  endfunction

  function automatic logic is_legal_aluc(
    input logic [ALUC_W-1:0] aluc
  );
    logic ok;
    ok = 1'b0;
    unique case (aluc)
      ALUC_ADD, ALUC_ADDU, ALUC_SUB,
      ALUC_SUBU, ALUC_AND, ALUC_OR,
      ALUC_XOR, ALUC_NOR, ALUC_SLT,
      ALUC_SLTU, ALUC_SLL, ALUC_SRL,
      ALUC_SRA, ALUC_SLLV, ALUC_SRLV,
      ALUC_SRAV, ALUC_LUI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_issue_stage_operand_fwd_mux.sv
// Source operand select: r0, EX/MEM bypass,
// MEM/WB bypass, then register-file value.
module operand_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] idx,
  input  logic [DATA_W-1:0] regval,
  input  logic              exm_valid,
  input  logic [REG_AW-1:0] exm_idx,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_valid,
  input  logic [REG_AW-1:0] mwb_idx,
  input  logic [DATA_W-1:0] mwb_data,
  output logic [DATA_W-1:0] val
);

  logic is_zero;
  logic hit_exm;
  logic hit_mwb;

  assign is_zero = (idx == '0);
  assign hit_exm = exm_valid && (exm_idx == idx);
  assign hit_mwb = mwb_valid && (mwb_idx == idx);

  always_comb begin
    val = regval;
    if (is_zero)      val = '0;
    else if (hit_exm) val = exm_data;
    else if (hit_mwb) val = mwb_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand forwarding, source mapping
// and a two-deep (output + skid) buffer toward EX.
module alu_issue_stage #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_AW = alu_pkg::REG_AW,
  parameter int ALUC_W = alu_pkg::ALUC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ALUC_W-1:0] in_aluc,
  input  logic [REG_AW-1:0] in_rs_idx,
  input  logic [REG_AW-1:0] in_rt_idx,
  input  logic [REG_AW-1:0] in_rd_idx,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [4:0]        in_shamt,
  input  logic              flush,
  input  logic              fwd_exm_valid,
  input  logic [REG_AW-1:0] fwd_exm_idx,
  input  logic [DATA_W-1:0] fwd_exm_data,
  input  logic              fwd_mwb_valid,
  input  logic [REG_AW-1:0] fwd_mwb_idx,
  input  logic [DATA_W-1:0] fwd_mwb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ALUC_W-1:0] out_aluc,
  output logic [REG_AW-1:0] out_rd_idx,
  output logic              out_illegal
);

  import alu_pkg::*;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  entry_t            out_q;
  entry_t            skid_q;
  entry_t            out_nx;
  entry_t            skid_nx;
  entry_t            out_snp;
  entry_t            skid_snp;
  entry_t            new_e;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic              accept;
  logic              consume;

  operand_fwd_mux #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rs (
    .idx      (in_rs_idx),
    .regval   (in_rs_val),
    .exm_valid(fwd_exm_valid),
    .exm_idx  (fwd_exm_idx),
    .exm_data (fwd_exm_data),
    .mwb_valid(fwd_mwb_valid),
    .mwb_idx  (fwd_mwb_idx),
    .mwb_data (fwd_mwb_data),
    .val      (rs_fwd)
  );

  operand_fwd_mux #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rt (
    .idx      (in_rt_idx),
    .regval   (in_rt_val),
    .exm_valid(fwd_exm_valid),
    .exm_idx  (fwd_exm_idx),
    .exm_data (fwd_exm_data),
    .mwb_valid(fwd_mwb_valid),
    .mwb_idx  (fwd_mwb_idx),
    .mwb_data (fwd_mwb_data),
    .val      (rt_fwd)
  );

  // Held entries only see MEM/WB: EX/MEM results
  // already reached them via MEM/WB or at accept.
  function automatic entry_t snoop(
    input entry_t            e,
    input logic              v,
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] data
  );
    entry_t r;
    logic   hit;
    r   = e;
    hit = v && (idx != '0);
    if (hit && e.a_is_reg && e.rs == idx) r.a = data;
    if (hit && e.b_is_reg && e.rt == idx) r.b = data;
    return r;
  endfunction

  always_comb begin
    new_e = '0;
    new_e.aluc     = in_aluc;
    new_e.rd       = in_rd_idx;
    new_e.rs       = in_rs_idx;
    new_e.rt       = in_rt_idx;
    new_e.a_is_reg = 1'b0;
    new_e.b_is_reg = !in_use_imm;
    new_e.b        = in_use_imm ? in_imm : rt_fwd;
    unique case (1'b1)
      is_shamt_op(in_aluc):
        new_e.a = {{(DATA_W-5){1'b0}}, in_shamt};
      (in_aluc == ALUC_LUI):
        new_e.a = in_imm;
      default: begin
        new_e.a        = rs_fwd;
        new_e.a_is_reg = 1'b1;
      end
    endcase
  end

  assign in_ready  = rst_n && (state != S_FULL);
  assign out_valid = (state != S_EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  assign out_snp  = snoop(out_q, fwd_mwb_valid,
                          fwd_mwb_idx, fwd_mwb_data);
  assign skid_snp = snoop(skid_q, fwd_mwb_valid,
                          fwd_mwb_idx, fwd_mwb_data);

  always_comb begin
    state_nx = state;
    out_nx   = out_snp;
    skid_nx  = skid_snp;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (accept) begin
            out_nx   = new_e;
            state_nx = S_ONE;
          end
        end
        S_ONE: begin
          unique case (1'b1)
            (accept && consume): out_nx = new_e;
            (accept && !consume): begin
              skid_nx  = new_e;
              state_nx = S_FULL;
            end
            (!accept && consume): state_nx = S_EMPTY;
            default: state_nx = S_ONE;
          endcase
        end
        S_FULL: begin
          if (consume) begin
            out_nx   = skid_snp;
            state_nx = S_ONE;
          end
        end
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nx;
      out_q  <= out_nx;
      skid_q <= skid_nx;
    end
  end

  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_aluc    = out_q.aluc;
  assign out_rd_idx  = out_q.rd;
  assign out_illegal = !is_legal_aluc(out_q.aluc);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed
// scenarios plus randomized traffic against a queue model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_aluc;
  logic [4:0]  in_rs_idx, in_rt_idx, in_rd_idx;
  logic [31:0] in_rs_val, in_rt_val, in_imm;
  logic        in_use_imm;
  logic [4:0]  in_shamt;
  logic        flush;
  logic        fwd_exm_valid;
  logic [4:0]  fwd_exm_idx;
  logic [31:0] fwd_exm_data;
  logic        fwd_mwb_valid;
  logic [4:0]  fwd_mwb_idx;
  logic [31:0] fwd_mwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [5:0]  out_aluc;
  logic [4:0]  out_rd_idx;
  logic        out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_aluc      (in_aluc),
    .in_rs_idx    (in_rs_idx),
    .in_rt_idx    (in_rt_idx),
    .in_rd_idx    (in_rd_idx),
    .in_rs_val    (in_rs_val),
    .in_rt_val    (in_rt_val),
    .in_imm       (in_imm),
    .in_use_imm   (in_use_imm),
    .in_shamt     (in_shamt),
    .flush        (flush),
    .fwd_exm_valid(fwd_exm_valid),
    .fwd_exm_idx  (fwd_exm_idx),
    .fwd_exm_data (fwd_exm_data),
    .fwd_mwb_valid(fwd_mwb_valid),
    .fwd_mwb_idx  (fwd_mwb_idx),
    .fwd_mwb_data (fwd_mwb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_aluc     (out_aluc),
    .out_rd_idx   (out_rd_idx),
    .out_illegal  (out_illegal)
  );

  localparam logic [5:0] LEGAL [17] = '{
    6'b100000, 6'b100001, 6'b100010, 6'b100011,
    6'b100100, 6'b100101, 6'b100110, 6'b100111,
    6'b101010, 6'b101011, 6'b000000, 6'b000010,
    6'b000011, 6'b000100, 6'b000110, 6'b000111,
    6'b001111
  };

  typedef struct {
    logic [31:0] a, b;
    logic [5:0]  aluc;
    logic [4:0]  rd, rs, rt;
    bit          ar, br;
  } m_t;

  m_t q[$];

  function automatic bit m_legal(logic [5:0] c);
    foreach (LEGAL[i]) if (LEGAL[i] == c) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_fwd(
    logic [4:0] idx, logic [31:0] rv);
    if (idx == 0) return 0;
    if (fwd_exm_valid && fwd_exm_idx == idx)
      return fwd_exm_data;
    if (fwd_mwb_valid && fwd_mwb_idx == idx)
      return fwd_mwb_data;
    return rv;
  endfunction

  task automatic idle();
    in_valid = 0; in_aluc = 0; in_rs_idx = 0;
    in_rt_idx = 0; in_rd_idx = 0; in_rs_val = 0;
    in_rt_val = 0; in_imm = 0; in_use_imm = 0;
    in_shamt = 0; flush = 0; fwd_exm_valid = 0;
    fwd_exm_idx = 0; fwd_exm_data = 0;
    fwd_mwb_valid = 0; fwd_mwb_idx = 0;
    fwd_mwb_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    out_ready = 0;
    rst_n = 0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_in_ready got %b want 0",
               in_ready);
    end
    tick(); tick();
    n_cmp++;
    if ({out_valid, out_a, out_b, out_aluc,
         out_rd_idx, out_illegal} !== '0) begin
      n_bad++;
      $display("FAIL rst_outs got v%b a%h b%h c%b want 0",
               out_valid, out_a, out_b, out_aluc);
    end
    rst_n = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_rst_ready got %b want 1",
               in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1;
    in_valid = 1; in_aluc = 6'b100001;
    in_rs_idx = 3; in_rs_val = 5;
    in_rt_idx = 4; in_rt_val = 7; in_rd_idx = 9;
    tick();
    idle();
    n_cmp++;
    if ({out_valid, out_a, out_b, out_aluc, out_rd_idx,
         in_ready} !== {1'b1, 32'd5, 32'd7, 6'b100001,
         5'd9, 1'b1}) begin
      n_bad++;
      $display("FAIL addu got v%b a%h b%h c%b rd%0d want 1 5 7 100001 9",
               out_valid, out_a, out_b, out_aluc, out_rd_idx);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL addu_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_shift_fwd();
    out_ready = 1;
    in_valid = 1; in_aluc = 6'b000010; in_shamt = 4;
    in_rs_idx = 7; in_rs_val = 32'hAAAA;
    in_rt_idx = 2; in_rt_val = 32'hF0;
    fwd_exm_valid = 1; fwd_exm_idx = 2;
    fwd_exm_data = 32'h100;
    tick();
    idle();
    n_cmp++;
    if ({out_a, out_b} !== {32'd4, 32'h100}) begin
      n_bad++;
      $display("FAIL srl_fwd got a%h b%h want 4 100",
               out_a, out_b);
    end
    tick();
  endtask

  task automatic test_zero_prio();
    out_ready = 1;
    in_valid = 1; in_aluc = 6'b100000;
    in_rs_idx = 0; in_rs_val = 32'h77;
    in_rt_idx = 1; in_rt_val = 9;
    fwd_exm_valid = 1; fwd_exm_idx = 0;
    fwd_exm_data = 32'hDEAD;
    tick();
    n_cmp++;
    if ({out_a, out_b} !== {32'd0, 32'd9}) begin
      n_bad++;
      $display("FAIL r0_fwd got a%h b%h want 0 9",
               out_a, out_b);
    end
    in_rs_idx = 6; in_rs_val = 32'h33;
    fwd_exm_idx = 6; fwd_exm_data = 32'h11;
    fwd_mwb_valid = 1; fwd_mwb_idx = 6;
    fwd_mwb_data = 32'h22;
    tick();
    idle();
    n_cmp++;
    if (out_a !== 32'h11) begin
      n_bad++;
      $display("FAIL fwd_prio got a%h want 11", out_a);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    in_valid = 1; in_aluc = 6'b100000;
    in_rs_idx = 1; in_rs_val = 1;
    in_rt_idx = 2; in_rt_val = 2; in_rd_idx = 10;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_rdy1 got %b want 1", in_ready);
    end
    tick();
    in_aluc = 6'b100010;
    in_rs_idx = 3; in_rs_val = 3;
    in_rt_idx = 4; in_rt_val = 4; in_rd_idx = 11;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_rdy2 got %b want 1", in_ready);
    end
    tick();
    in_aluc = 6'b100100; in_rd_idx = 12;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_rdy3 got %b want 0", in_ready);
    end
    tick();
    idle();
    fwd_mwb_valid = 1; fwd_mwb_idx = 4;
    fwd_mwb_data = 32'h55;
    tick();
    idle();
    n_cmp++;
    if ({out_valid, out_a, out_b, out_rd_idx} !==
        {1'b1, 32'd1, 32'd2, 5'd10}) begin
      n_bad++;
      $display("FAIL b2b_hold got v%b a%h b%h rd%0d want 1 1 2 10",
               out_valid, out_a, out_b, out_rd_idx);
    end
    out_ready = 1;
    tick();
    n_cmp++;
    if ({out_valid, out_a, out_b, out_rd_idx} !==
        {1'b1, 32'd3, 32'h55, 5'd11}) begin
      n_bad++;
      $display("FAIL b2b_snoop got v%b a%h b%h rd%0d want 1 3 55 11",
               out_valid, out_a, out_b, out_rd_idx);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_aluc = 6'b100101;
    in_rs_idx = 1; in_rs_val = 8;
    tick(); tick();
    flush = 1;
    tick();
    idle();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush got v%b r%b want 0 1",
               out_valid, in_ready);
    end
    out_ready = 1;
    tick(); tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_empty got %b want 0", out_valid);
    end
  endtask

  task automatic test_illegal_lui();
    out_ready = 1;
    in_valid = 1; in_aluc = 6'b111111;
    tick();
    n_cmp++;
    if ({out_valid, out_illegal} !== 2'b11) begin
      n_bad++;
      $display("FAIL illegal got v%b i%b want 1 1",
               out_valid, out_illegal);
    end
    in_aluc = 6'b001111; in_imm = 32'h1234;
    in_use_imm = 1;
    tick();
    idle();
    n_cmp++;
    if ({out_a, out_illegal} !== {32'h1234, 1'b0}) begin
      n_bad++;
      $display("FAIL lui got a%h i%b want 1234 0",
               out_a, out_illegal);
    end
    tick();
  endtask

  task automatic test_random();
    m_t  e;
    bit  acc, con;
    q.delete();
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) < 17)
        in_aluc = LEGAL[$urandom_range(0, 16)];
      else
        in_aluc = 6'($urandom);
      in_rs_idx = 5'($urandom_range(0, 7));
      in_rt_idx = 5'($urandom_range(0, 7));
      in_rd_idx = 5'($urandom);
      in_rs_val = $urandom; in_rt_val = $urandom;
      in_imm = $urandom; in_use_imm = 1'($urandom);
      in_shamt = 5'($urandom);
      fwd_exm_valid = 1'($urandom);
      fwd_exm_idx = 5'($urandom_range(0, 7));
      fwd_exm_data = $urandom;
      fwd_mwb_valid = 1'($urandom);
      fwd_mwb_idx = 5'($urandom_range(0, 7));
      fwd_mwb_data = $urandom;
      e.aluc = in_aluc; e.rd = in_rd_idx;
      e.rs = in_rs_idx; e.rt = in_rt_idx;
      e.br = !in_use_imm;
      e.b = in_use_imm ? in_imm : m_fwd(in_rt_idx, in_rt_val);
      e.ar = 0;
      if (in_aluc inside {6'b000000, 6'b000010, 6'b000011})
        e.a = {27'd0, in_shamt};
      else if (in_aluc == 6'b001111)
        e.a = in_imm;
      else begin
        e.a = m_fwd(in_rs_idx, in_rs_val);
        e.ar = 1;
      end
      acc = in_valid && q.size() < 2;
      con = out_ready && q.size() > 0;
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (fwd_mwb_valid && fwd_mwb_idx != 0)
          foreach (q[k]) begin
            if (q[k].ar && q[k].rs == fwd_mwb_idx)
              q[k].a = fwd_mwb_data;
            if (q[k].br && q[k].rt == fwd_mwb_idx)
              q[k].b = fwd_mwb_data;
          end
        if (con) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      #1;
      n_cmp++;
      if ({out_valid, in_ready} !==
          {q.size() > 0, q.size() < 2}) begin
        n_bad++;
        $display("FAIL rnd_hs[%0d] got v%b r%b want depth %0d",
                 i, out_valid, in_ready, q.size());
      end
      if (q.size() > 0) begin
        n_cmp++;
        if ({out_a, out_b, out_aluc, out_rd_idx,
             out_illegal} !== {q[0].a, q[0].b, q[0].aluc,
             q[0].rd, !m_legal(q[0].aluc)}) begin
          n_bad++;
          $display("FAIL rnd_data[%0d] got a%h b%h c%b rd%0d i%b want a%h b%h c%b rd%0d",
                   i, out_a, out_b, out_aluc, out_rd_idx,
                   out_illegal, q[0].a, q[0].b, q[0].aluc,
                   q[0].rd);
        end
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    out_ready = 0;
    in_valid = 1; in_aluc = 6'b100000;
    tick(); tick();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, out_a, out_b} !==
        {1'b0, 1'b1, 64'd0}) begin
      n_bad++;
      $display("FAIL mid_rst got v%b r%b a%h b%h want 0 1 0 0",
               out_valid, in_ready, out_a, out_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift_fwd();
    test_zero_prio();
    test_back_to_back();
    test_flush();
    test_illegal_lui();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU.
- Accepts decoded instructions from ID with a valid/ready handshake and resolves operand forwarding.
- Maps shift-amount, immediate and LUI sources onto the ALU a/b inputs.
- Buffers up to two instructions (output register plus skid entry) and presents registered a, b and aluc to the ALU with a valid/ready handshake toward EX.

Parameters:
- DATA_W, 32, operand width
- REG_AW, 5, register index width
- ALUC_W, 6, ALU opcode width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_aluc  in  ALUC_W  ALU opcode (ALU encoding: ADD 100000 … SRAV 000111, LUI 001111)
- in_rs_idx, in_rt_idx, in_rd_idx  in  REG_AW each  source and destination indices
- in_rs_val, in_rt_val  in  DATA_W each  register-file read data
- in_imm  in  DATA_W  extended immediate
- in_use_imm  in  1  b takes in_imm instead of rt
- in_shamt  in  5  shift amount for SLL/SRL/SRA
- flush  in  1  discard all held and incoming instructions
- fwd_exm_valid, fwd_exm_idx, fwd_exm_data  in  1/REG_AW/DATA_W  EX/MEM result bypass
- fwd_mwb_valid, fwd_mwb_idx, fwd_mwb_data  in  1/REG_AW/DATA_W  MEM/WB writeback bypass
- out_valid  out  1  ALU operands valid
- out_ready  in  1  EX consumes this cycle
- out_a, out_b  out  DATA_W each  ALU operands
- out_aluc  out  ALUC_W  ALU opcode
- out_rd_idx  out  REG_AW  destination index
- out_illegal  out  1  out_aluc is not a supported code

Behaviour:
- Reset (rst_n low at clk edge):
  - out_valid=0, out_a=0, out_b=0, out_aluc=0, out_rd_idx=0, out_illegal=0.
  - Skid entry cleared; state EMPTY.
  - in_ready=0 while rst_n is low.
  - Reset mid-operation drops all held entries.
- Handshake:
  - Input accept occurs when in_valid&&in_ready.
  - Output consume occurs when out_valid&&out_ready.
  - in_ready = (state != FULL); no combinational path from out_ready to in_ready.
- States:
  - EMPTY: accept -> ONE.
  - ONE: accept and no consume -> FULL (new entry goes into skid). Consume and no accept -> EMPTY. Both -> ONE (new entry goes into output register).
  - FULL: consume -> ONE (skid moves to output register). No consume -> FULL.
- Latency: 1 cycle from accept to out_valid in EMPTY. Throughput: 1 instruction per cycle.
- out_* hold stable while out_valid&&!out_ready.
- Operand a, captured at accept:
  - aluc ∈ {SLL,SRL,SRA}: a = zero-extended in_shamt.
  - aluc = LUI: a = in_imm.
  - Otherwise: a = fwd(rs).
- Operand b, captured at accept: b = in_use_imm ? in_imm : fwd(rt).
- fwd(idx, regval):
  - idx==0 -> 0.
  - Else EX/MEM match -> fwd_exm_data.
  - Else MEM/WB match -> fwd_mwb_data.
  - Else regval.
  - EX/MEM has priority over MEM/WB.
- Held-entry snoop:
  - Each entry stores rs/rt indices and flags a_is_reg/b_is_reg.
  - Every cycle an entry is held (not accepted this cycle), a valid MEM/WB write whose index is nonzero and matches a flagged source replaces that operand.
  - EX/MEM is not snooped for held entries.
- out_illegal = out_aluc not in {ADD,ADDU,SUB,SUBU,AND,OR,XOR,NOR,SLT,SLTU,SLL,SRL,SRA,SLLV,SRLV,SRAV,LUI}.
  - Illegal entries still flow normally.
- Flush:
  - Synchronous; takes priority over accept and consume.
  - Next cycle: state EMPTY, out_valid=0, in_ready=1.
  - An instruction presented in the flush cycle is discarded.
  - Data registers are not cleared.
- Simultaneous FULL with consume and in_valid: in_ready=0, so nothing is accepted; the next state is ONE.

Decomposition:
- Package alu_pkg:
  - ALUC_* localparams for all 17 codes and DATA_W/REG_AW/ALUC_W.
  - Function is_shamt_op(aluc).
  - Function is_legal_aluc(aluc).
  - Entry struct {a, b, aluc, rd, rs, rt, a_is_reg, b_is_reg}.
- One sub-module, operand_fwd_mux: combinational idx/regval/bypass priority select, instantiated twice.

Test Plan:
- Reset, then in_valid=1 with ADDU, rs=3 (val 5), rt=4 (val 7), out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7, out_aluc=100001; in_ready=1 throughout.
- SRL with shamt=4, rt=2 (val 0xF0), EX/MEM writing r2=0x100 -> out_a=4, out_b=0x100.
- rs=0 with fwd_exm_idx=0 and data 0xDEAD -> out_a=0. Both bypasses matching rs=6 (EX/MEM 0x11, MEM/WB 0x22) -> out_a=0x11.
- out_ready=0 with three back-to-back in_valid -> two accepted, in_ready=0 on cycle 3. Then MEM/WB writes rt of the skid entry with 0x55 -> that entry later exits with out_b=0x55. Order preserved.
- FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no entry emerges.
- in_aluc=6'b111111 -> out_illegal=1. Then LUI with imm=0x1234 -> out_a=0x1234, out_illegal=0.
